// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer for the 16x8 synchronous FIFO.
// Issues FIFO reads from registered state and FIFO flags only, captures the
// registered FIFO read data one cycle later into a 3-entry circular buffer,
// and presents the buffer head as a valid/ready stream. A small FSM provides
// enable and flush control.
// Optional feature macro: FIFO_RD_STATS_EN adds the rd_words transfer counter
// and the sticky err_underflow flag.
module fifo_rd_stream #(
    parameter int FIFO_WIDTH = 16,
    parameter int BUF_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_underflow,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic                  flush_done
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0]           rd_words,
    output logic                  err_underflow
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // The issue decision counts buffered words plus the one word in flight,
    // so the buffer can never be overrun even though m_ready is not consulted.
    localparam logic [2:0] BUF_LIMIT = 3'(BUF_DEPTH);

    // Circular pointer advance with wrap 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        logic [1:0] r;
        if (p == 2'd2) begin
            r = 2'd0;
        end else begin
            r = p + 2'd1;
        end
        return r;
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic [1:0]            head_q, head_d;
    logic [1:0]            tail_q, tail_d;
    logic                  inflight_q, inflight_d;
    logic                  flush_done_q, flush_done_d;
    logic [FIFO_WIDTH-1:0] buf_q [BUF_DEPTH];

    logic                  rd_en_s;
    logic                  m_valid_s;
    logic                  pop_s;
    logic                  capture_s;
    logic [2:0]            pending_s;
    logic [FIFO_WIDTH-1:0] head_data_s;

    assign pending_s = {1'b0, occ_q} + {2'b00, inflight_q};
    assign m_valid_s = (occ_q != 2'd0) && (state_q != ST_FLUSH);
    assign pop_s     = m_valid_s && m_ready;
    assign capture_s = inflight_q && (state_q != ST_FLUSH);

    // Read issue: RUN obeys buffer room, FLUSH drains regardless, IDLE never reads.
    always_comb begin
        rd_en_s = 1'b0;
        case (state_q)
            ST_RUN:   rd_en_s = en && !fifo_empty && (pending_s < BUF_LIMIT);
            ST_FLUSH: rd_en_s = !fifo_empty;
            default:  rd_en_s = 1'b0;
        endcase
    end

    // Buffer head selection for the stream data output.
    always_comb begin
        head_data_s = buf_q[0];
        case (head_q)
            2'd1:    head_data_s = buf_q[1];
            2'd2:    head_data_s = buf_q[2];
            default: head_data_s = buf_q[0];
        endcase
    end

    // Next-state logic: FSM transitions, pointer movement and occupancy.
    always_comb begin
        state_d      = state_q;
        occ_d        = occ_q;
        head_d       = head_q;
        tail_d       = tail_q;
        flush_done_d = 1'b0;
        inflight_d   = rd_en_s && !fifo_empty;

        if (capture_s) begin
            tail_d = ptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end

        if (pop_s) begin
            head_d = ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end

        case ({capture_s, pop_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                    occ_d   = 2'd0;
                    head_d  = 2'd0;
                    tail_d  = 2'd0;
                end else if (en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_FLUSH;
                    occ_d   = 2'd0;
                    head_d  = 2'd0;
                    tail_d  = 2'd0;
                end else if (!en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // Buffer stays empty; arriving words are dropped.
                occ_d  = 2'd0;
                head_d = 2'd0;
                tail_d = 2'd0;
                if (fifo_empty && !inflight_q) begin
                    state_d      = ST_IDLE;
                    flush_done_d = 1'b1;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                occ_d   = 2'd0;
                head_d  = 2'd0;
                tail_d  = 2'd0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            occ_q        <= 2'd0;
            head_q       <= 2'd0;
            tail_q       <= 2'd0;
            inflight_q   <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            inflight_q   <= inflight_d;
            flush_done_q <= flush_done_d;
        end
    end

    // Buffer storage: the in-flight FIFO word lands at the tail entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= {FIFO_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (capture_s && (tail_q == 2'(i))) begin
                    buf_q[i] <= fifo_data_out;
                end
            end
        end
    end

    assign fifo_rd_en = rd_en_s;
    assign m_valid    = m_valid_s;
    assign m_data     = head_data_s;
    assign busy       = (state_q != ST_IDLE) || inflight_q;
    assign flush_done = flush_done_q;

`ifdef FIFO_RD_STATS_EN
    logic [15:0] rd_words_q;
    logic        err_underflow_q;

    // Transfer counter (saturating, survives flush) and sticky underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_words_q      <= 16'h0000;
            err_underflow_q <= 1'b0;
        end else begin
            if (pop_s && (rd_words_q != 16'hFFFF)) begin
                rd_words_q <= rd_words_q + 16'h0001;
            end
            if (fifo_underflow) begin
                err_underflow_q <= 1'b1;
            end
        end
    end

    assign rd_words      = rd_words_q;
    assign err_underflow = err_underflow_q;
`else
    logic unused_underflow_s;
    assign unused_underflow_s = fifo_underflow;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: behavioural 16x8 FIFO model, directed
// stimulus, and a scoreboard queue checked by an independent stream monitor.
module tb_fifo_rd_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic        fifo_empty;
    logic [15:0] fifo_data_out;
    logic        fifo_underflow;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        busy;
    logic        flush_done;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] rd_words;
    logic        err_underflow;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q [$];

    // FIFO model state
    logic [15:0] fmem [8];
    logic [2:0]  fwp, frp;
    logic [3:0]  fcnt;
    logic [15:0] fdout;
    logic        fuf;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        force_uf;
    logic        f_do_rd, f_do_wr;

    // Bench-side occupancy tracker built from port activity only
    logic chk_occ;
    int   occ_tb;
    logic inf_tb;
    int   viol_cnt  = 0;
    int   uf_cnt    = 0;
    int   rd_empty_cnt = 0;

    always #5 clk = ~clk;

    fifo_rd_stream dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .flush          (flush),
        .fifo_empty     (fifo_empty),
        .fifo_data_out  (fifo_data_out),
        .fifo_underflow (fifo_underflow),
        .fifo_rd_en     (fifo_rd_en),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .busy           (busy),
        .flush_done     (flush_done)
`ifdef FIFO_RD_STATS_EN
        ,
        .rd_words       (rd_words),
        .err_underflow  (err_underflow)
`endif
    );

    assign f_do_rd        = fifo_rd_en && (fcnt != 4'd0);
    assign f_do_wr        = wr_en && (fcnt != 4'd8);
    assign fifo_empty     = (fcnt == 4'd0);
    assign fifo_data_out  = fdout;
    assign fifo_underflow = fuf | force_uf;

    // Synchronous FIFO model with registered read data
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwp   <= 3'd0;
            frp   <= 3'd0;
            fcnt  <= 4'd0;
            fdout <= 16'h0000;
            fuf   <= 1'b0;
        end else begin
            if (f_do_wr) begin
                fmem[fwp] <= wr_data;
                fwp       <= fwp + 3'd1;
            end
            if (f_do_rd) begin
                fdout <= fmem[frp];
                frp   <= frp + 3'd1;
            end
            fuf  <= fifo_rd_en && (fcnt == 4'd0);
            fcnt <= fcnt + {3'd0, f_do_wr} - {3'd0, f_do_rd};
        end
    end

    // Occupancy tracker: in-flight read, then captured, then drained
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_tb <= 0;
            inf_tb <= 1'b0;
        end else if (!chk_occ) begin
            occ_tb <= 0;
            inf_tb <= 1'b0;
        end else begin
            inf_tb <= fifo_rd_en && !fifo_empty;
            occ_tb <= occ_tb + (inf_tb ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Stream monitor: every transfer is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_transfer", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                check("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
        if (rst_n && fuf) uf_cnt++;
        if (rst_n && fifo_rd_en && fifo_empty) rd_empty_cnt++;
        if (rst_n && chk_occ && fifo_rd_en && ((occ_tb + (inf_tb ? 1 : 0)) == 3)) viol_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] d, input bit expect_it);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        if (expect_it) exp_q.push_back(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_cnt, vcnt, first_rd, last_rd, first_v, last_v, x_cnt, fd_cnt, bad_hold;
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
        wr_en = 1'b0; wr_data = 16'h0000; force_uf = 1'b0; chk_occ = 1'b0;
        #12;
        check("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_m_valid",    32'(m_valid),    32'd0);
        check("rst_m_data",     32'(m_data),     32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_flush_done", 32'(flush_done), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Test 1: full FIFO streamed at full rate
        for (int i = 1; i <= 8; i++) push_word(16'(i), 1'b1);
        m_ready = 1'b1;
        en      = 1'b1;
        rd_cnt = 0; vcnt = 0; first_rd = -1; last_rd = -1; first_v = -1; last_v = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = c;
                last_rd = c;
            end
            if (m_valid) begin
                vcnt++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
        end
        check("t1_read_count",      32'(rd_cnt),           32'd8);
        check("t1_read_contiguous", 32'(last_rd - first_rd), 32'd7);
        check("t1_latency",         32'(first_v - first_rd), 32'd2);
        check("t1_valid_count",     32'(vcnt),             32'd8);
        check("t1_valid_contiguous",32'(last_v - first_v), 32'd7);
        check("t1_valid_low_after", 32'(m_valid),          32'd0);
        check("t1_scoreboard_empty",32'(exp_q.size()),     32'd0);
`ifdef FIFO_RD_STATS_EN
        check("t1_rd_words",        32'(rd_words),         32'd8);
`endif

        // Test 2: backpressure with 5 words, only 3 may be fetched
        tick();
        en = 1'b0; m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_word(16'h0A00 + 16'(i), 1'b1);
        en = 1'b1;
        rd_cnt = 0; bad_hold = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_cnt++;
            if (m_valid && (m_data != 16'h0A01)) bad_hold++;
        end
        check("t2_reads_while_stalled", 32'(rd_cnt),   32'd3);
        check("t2_fifo_left",           32'(fcnt),     32'd2);
        check("t2_valid_held",          32'(m_valid),  32'd1);
        check("t2_head_data",           32'(m_data),   32'h0A01);
        check("t2_head_stable",         32'(bad_hold), 32'd0);
        tick();
        m_ready = 1'b1;
        x_cnt = 0; first_v = -1; last_v = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                x_cnt++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
        end
        check("t2_transfer_count", 32'(x_cnt),           32'd5);
        check("t2_no_gaps",        32'(last_v - first_v), 32'd4);
        check("t2_scoreboard_empty", 32'(exp_q.size()),   32'd0);

        // Test 3: alternating ready over 8 words
        tick();
        en = 1'b0; m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_word(16'hB000 + 16'(i), 1'b1);
        chk_occ = 1'b1;
        en = 1'b1;
        for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin
            tick();
            m_ready = ~m_ready;
        end
        check("t3_all_delivered", 32'(exp_q.size()), 32'd0);
        tick();
        chk_occ = 1'b0;
        m_ready = 1'b0;
        check("t3_no_overissue", 32'(viol_cnt), 32'd0);

        // Test 4: flush with 3 buffered and 4 left in the FIFO
        en = 1'b0;
        for (int i = 1; i <= 7; i++) push_word(16'hC000 + 16'(i), 1'b0);
        en = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        check("t4_fifo_remaining", 32'(fcnt),    32'd4);
        check("t4_buffered_valid", 32'(m_valid), 32'd1);
        flush = 1'b1;
        en    = 1'b0;
        tick();
        flush = 1'b0;
        rd_cnt = 0; fd_cnt = 0; x_cnt = 0;
        @(negedge clk);
        check("t4_valid_dropped", 32'(m_valid), 32'd0);
        if (fifo_rd_en) rd_cnt++;
        if (flush_done) fd_cnt++;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_cnt++;
            if (flush_done) fd_cnt++;
            if (m_valid) x_cnt++;
        end
        check("t4_drain_reads", 32'(rd_cnt), 32'd4);
        check("t4_flush_done",  32'(fd_cnt), 32'd1);
        check("t4_idle_busy",   32'(busy),   32'd0);
        check("t4_no_output",   32'(x_cnt),  32'd0);
        check("t4_fifo_empty",  32'(fcnt),   32'd0);
        tick();
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        m_ready = 1'b0;

`ifdef FIFO_RD_STATS_EN
        // Sticky underflow flag
        force_uf = 1'b1;
        tick();
        force_uf = 1'b0;
        tick();
        check("st_err_set", 32'(err_underflow), 32'd1);
        for (int c = 0; c < 5; c++) tick();
        check("st_err_sticky", 32'(err_underflow), 32'd1);
        check("st_words_after_flush", 32'(rd_words), 32'd21);
`endif

        // Test 5: asynchronous reset with occ=2 and a read in flight
        en = 1'b0;
        for (int i = 1; i <= 5; i++) push_word(16'hD000 + 16'(i), 1'b0);
        en = 1'b1;
        rd_cnt = 0;
        for (int c = 0; c < 20 && rd_cnt < 3; c++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_cnt++;
        end
        check("t5_setup_reads", 32'(rd_cnt), 32'd3);
        tick();
        check("t5_pre_busy",  32'(busy),    32'd1);
        check("t5_pre_valid", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(m_valid),    32'd0);
        check("t5_async_rd_en", 32'(fifo_rd_en), 32'd0);
        check("t5_async_busy",  32'(busy),       32'd0);
        check("t5_async_data",  32'(m_data),     32'd0);
`ifdef FIFO_RD_STATS_EN
        check("st_err_cleared",   32'(err_underflow), 32'd0);
        check("st_words_cleared", 32'(rd_words),      32'd0);
`endif
        tick();
        rst_n = 1'b1;
        rd_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (fifo_rd_en) rd_cnt++;
        end
        check("t5_no_reads_empty", 32'(rd_cnt), 32'd0);

        check("no_fifo_underflow", 32'(uf_cnt),       32'd0);
        check("no_read_when_empty", 32'(rd_empty_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
